// File: rtl/traffic_monitor.sv
// Traffic-light lamp monitor.
// Watches the four lamp buses of a traffic controller (M1, M2, MT, S) and
// latches sticky faults: bad lamp encoding, conflicting greens, illegal
// colour sequence, too-short green/yellow phases and, optionally, red
// starvation. Also counts M1 red->green transitions.
// Optional feature: define TRAFFIC_MONITOR_STARVATION_EN to build the red
// starvation watchdog (fault_vec[4]); otherwise fault_vec[4] is tied to 0.
module traffic_monitor #(
  parameter int MIN_GREEN  = 5,
  parameter int MIN_YELLOW = 2,
  parameter int MAX_RED    = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  light_M1,
  input  logic [2:0]  light_M2,
  input  logic [2:0]  light_MT,
  input  logic [2:0]  light_S,
  input  logic        clr,
  output logic        fault,
  output logic [4:0]  fault_vec,
  output logic [1:0]  first_src,
  output logic [15:0] cycle_cnt
);

  // Tracker encoding; UNKNOWN means "no trustworthy colour yet".
  localparam logic [1:0] ST_RED     = 2'd0;
  localparam logic [1:0] ST_GREEN   = 2'd1;
  localparam logic [1:0] ST_YELLOW  = 2'd2;
  localparam logic [1:0] ST_UNKNOWN = 2'd3;

  localparam logic [15:0] MIN_GREEN_W  = 16'(MIN_GREEN);
  localparam logic [15:0] MIN_YELLOW_W = 16'(MIN_YELLOW);
`ifdef TRAFFIC_MONITOR_STARVATION_EN
  localparam logic [15:0] MAX_RED_W    = 16'(MAX_RED);
`endif

  // Lamp buses gathered by approach index (0 = M1 .. 3 = S).
  logic [2:0]  cur [4];
  assign cur[0] = light_M1;
  assign cur[1] = light_M2;
  assign cur[2] = light_MT;
  assign cur[3] = light_S;

  // Per-approach state.
  logic [2:0]  prev_q  [4];
  logic [1:0]  state_q [4];
  logic [1:0]  state_d [4];
  logic [15:0] dwell_q [4];
  logic [15:0] dwell_d [4];
  logic        valid_q;

  // Global sticky state.
  logic [4:0]  fault_vec_q, fault_vec_d;
  logic [1:0]  first_src_q, first_src_d;
  logic [15:0] cycle_cnt_q, cycle_cnt_d;

  // Fault events detected on the current sample.
  logic [3:0]  onehot;
  logic [3:0]  enc_bad;
  logic [3:0]  seq_bad;
  logic [3:0]  dwell_bad;
  logic [3:0]  starve_bad;
  logic [3:0]  conf_mask;
  logic [3:0]  green;
  logic [3:0]  src_mask;
  logic [4:0]  new_flags;
  logic        m1_r2g;

  // State register: trackers, dwell counters, sample history and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        prev_q[i]  <= 3'b000;
        state_q[i] <= ST_UNKNOWN;
        dwell_q[i] <= 16'd0;
      end
      valid_q     <= 1'b0;
      fault_vec_q <= 5'd0;
      first_src_q <= 2'd0;
      cycle_cnt_q <= 16'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        prev_q[i]  <= cur[i];
        state_q[i] <= state_d[i];
        dwell_q[i] <= dwell_d[i];
      end
      valid_q     <= 1'b1;
      fault_vec_q <= fault_vec_d;
      first_src_q <= first_src_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  // Next-state: decode each bus into a colour and advance its dwell counter.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      onehot[i]  = 1'b0;
      state_d[i] = ST_UNKNOWN;
      case (cur[i])
        3'b001:  begin onehot[i] = 1'b1; state_d[i] = ST_GREEN;  end
        3'b010:  begin onehot[i] = 1'b1; state_d[i] = ST_YELLOW; end
        3'b100:  begin onehot[i] = 1'b1; state_d[i] = ST_RED;    end
        default: begin onehot[i] = 1'b0; state_d[i] = ST_UNKNOWN; end
      endcase
      if (state_d[i] != state_q[i]) begin
        dwell_d[i] = 16'd1;
      end else if (dwell_q[i] == 16'hFFFF) begin
        dwell_d[i] = 16'hFFFF;
      end else begin
        dwell_d[i] = dwell_q[i] + 16'd1;
      end
    end
  end

  // Output/check logic: sequence, min-dwell and starvation per approach.
  always_comb begin
    enc_bad    = 4'd0;
    seq_bad    = 4'd0;
    dwell_bad  = 4'd0;
    starve_bad = 4'd0;
    for (int i = 0; i < 4; i++) begin
      enc_bad[i] = !onehot[i];
      // Only a genuine colour change from a known colour is checked; the
      // first good value after UNKNOWN simply reloads the tracker.
      if (valid_q && (state_q[i] != ST_UNKNOWN) && onehot[i] &&
          (cur[i] != prev_q[i])) begin
        seq_bad[i] = !(((state_q[i] == ST_RED)    && (state_d[i] == ST_GREEN))  ||
                       ((state_q[i] == ST_GREEN)  && (state_d[i] == ST_YELLOW)) ||
                       ((state_q[i] == ST_YELLOW) && (state_d[i] == ST_RED)));
        dwell_bad[i] = ((state_q[i] == ST_GREEN) && (state_d[i] == ST_YELLOW) &&
                        (dwell_q[i] < MIN_GREEN_W)) ||
                       ((state_q[i] == ST_YELLOW) && (state_d[i] == ST_RED) &&
                        (dwell_q[i] < MIN_YELLOW_W));
      end
`ifdef TRAFFIC_MONITOR_STARVATION_EN
      starve_bad[i] = (state_d[i] == ST_RED) && (dwell_d[i] > MAX_RED_W);
`endif
    end
  end

  // Conflicting greens: S against anyone, MT against M2. Each approach
  // in a conflicting pair is marked so the lowest index reports it.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      green[i] = cur[i][0];
    end
    conf_mask[0] = green[3] & green[0];
    conf_mask[1] = (green[3] & green[1]) | (green[2] & green[1]);
    conf_mask[2] = (green[3] & green[2]) | (green[2] & green[1]);
    conf_mask[3] = green[3] & (green[0] | green[1] | green[2]);
  end

  // Combine events into sticky flags, first source and the M1 cycle count.
  always_comb begin
    new_flags[0] = |enc_bad;
    new_flags[1] = |conf_mask;
    new_flags[2] = |seq_bad;
    new_flags[3] = |dwell_bad;
`ifdef TRAFFIC_MONITOR_STARVATION_EN
    new_flags[4] = |starve_bad;
    src_mask     = enc_bad | conf_mask | seq_bad | dwell_bad | starve_bad;
`else
    new_flags[4] = 1'b0;
    src_mask     = enc_bad | conf_mask | seq_bad | dwell_bad;
`endif

    // A new fault on a clearing cycle survives the clear.
    fault_vec_d = clr ? new_flags : (fault_vec_q | new_flags);

    first_src_d = clr ? 2'd0 : first_src_q;
    if ((clr || (fault_vec_q == 5'd0)) && (src_mask != 4'd0)) begin
      if (src_mask[0])      first_src_d = 2'd0;
      else if (src_mask[1]) first_src_d = 2'd1;
      else if (src_mask[2]) first_src_d = 2'd2;
      else                  first_src_d = 2'd3;
    end

    m1_r2g      = valid_q && (state_q[0] == ST_RED) && (state_d[0] == ST_GREEN);
    cycle_cnt_d = m1_r2g ? (cycle_cnt_q + 16'd1) : cycle_cnt_q;
  end

  // Outputs come straight from registers, so they are 0 throughout reset.
  assign fault_vec = fault_vec_q;
  assign fault     = |fault_vec_q;
  assign first_src = first_src_q;
  assign cycle_cnt = cycle_cnt_q;

  // Starvation vector is only consumed when the watchdog is built in.
  logic unused_ok;
  assign unused_ok = ^starve_bad;

endmodule
